// File: rtl/uncache_arbiter_if.sv
// ---------------------------------------------------------------------------
// uncache_arbiter_if
//
// Groups the signals around the uncached arbiter: the instruction-side and
// data-side uncached requesters and the single-beat SRAM-like bus towards
// the uncached AXI bridge.
//
// Signals:
//   i_req/i_addr/i_kill   instruction request, physical address, squash
//   i_done/i_rdata        instruction completion pulse and fetched word
//   d_req/d_wr/d_size/d_addr/d_wdata  data request and its fields
//   d_done/d_rdata        data completion pulse and load data
//   bus_req/bus_wr/bus_size/bus_addr/bus_wdata  bus address phase
//   bus_addr_ok/bus_data_ok/bus_rdata           bus responses
//   busy                  arbiter has a transaction in flight
//
// Modports:
//   slave  - the arbiter's view (it serves the requesters, drives the bus)
//   master - the surrounding environment (requesters plus bus responder)
// ---------------------------------------------------------------------------
interface uncache_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_kill;
  logic        i_done;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_wr;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;

  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  logic        busy;

  modport slave (
    input  i_req, i_addr, i_kill,
    output i_done, i_rdata,
    input  d_req, d_wr, d_size, d_addr, d_wdata,
    output d_done, d_rdata,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata,
    output busy
  );

  modport master (
    output i_req, i_addr, i_kill,
    input  i_done, i_rdata,
    output d_req, d_wr, d_size, d_addr, d_wdata,
    input  d_done, d_rdata,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata,
    input  busy
  );
endinterface

// File: rtl/uncache_arbiter.sv
// ---------------------------------------------------------------------------
// uncache_arbiter
//
// Shares the single uncached memory port between the instruction-side and
// data-side uncached requesters. Each access becomes one single-beat
// transaction on an SRAM-like bus; simultaneous requests are served
// round-robin. Addresses are physical and forwarded unchanged.
//
// Ports:
//   clk     system clock
//   resetn  asynchronous active-low reset
//   uif     uncache_arbiter_if.slave: requester handshakes, bus, busy
//
// Every output is decoded from the state register or from registers
// latched at grant time, so there is no combinational path from any input
// to any output.
// ---------------------------------------------------------------------------
module uncache_arbiter (
  input  logic              clk,
  input  logic              resetn,
  uncache_arbiter_if.slave  uif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t      state_reg, state_next;
  logic        grant_reg, grant_next;
  logic        last_grant_reg, last_grant_next;
  logic        kill_flag_reg, kill_flag_next;
  logic        wr_reg, wr_next;
  logic [1:0]  size_reg, size_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rdata_reg, rdata_next;

  // Winner of IDLE arbitration: on a tie the side that did not win last.
  logic arb_win;
  assign arb_win = (uif.i_req && uif.d_req) ? ~last_grant_reg : uif.d_req;

  // -------------------------------------------------------------------------
  // State and latched-field registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      grant_reg      <= GRANT_I;
      last_grant_reg <= GRANT_I;
      kill_flag_reg  <= 1'b0;
      wr_reg         <= 1'b0;
      size_reg       <= 2'd0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      rdata_reg      <= 32'd0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      kill_flag_reg  <= kill_flag_next;
      wr_reg         <= wr_next;
      size_reg       <= size_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      rdata_reg      <= rdata_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    kill_flag_next  = kill_flag_reg;
    wr_next         = wr_reg;
    size_next       = size_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    rdata_next      = rdata_reg;

    unique case (state_reg)
      IDLE: begin
        if (uif.i_req || uif.d_req) begin
          grant_next      = arb_win;
          last_grant_next = arb_win;
          kill_flag_next  = 1'b0;
          if (arb_win == GRANT_D) begin
            wr_next    = uif.d_wr;
            size_next  = uif.d_size;
            addr_next  = uif.d_addr;
            wdata_next = uif.d_wdata;
          end else begin
            // Fetches are always word loads; write data is left as is.
            wr_next    = 1'b0;
            size_next  = 2'd2;
            addr_next  = uif.i_addr;
          end
          state_next = ADDR;
        end
      end

      ADDR: begin
        // bus_data_ok without bus_addr_ok cannot belong to this access.
        if (uif.bus_addr_ok) begin
          if (uif.bus_data_ok) begin
            rdata_next = uif.bus_rdata;
            state_next = RESP;
          end else begin
            state_next = DATA;
          end
        end
      end

      DATA: begin
        if (uif.bus_data_ok) begin
          rdata_next = uif.bus_rdata;
          state_next = RESP;
        end
      end

      RESP: begin
        state_next = IDLE;
      end
    endcase

    // A squash only marks the fetch; the bus transaction is never
    // withdrawn, since the bridge may already have accepted it.
    if (uif.i_kill && grant_reg == GRANT_I && state_reg != IDLE) begin
      kill_flag_next = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign uif.bus_req   = (state_reg == ADDR);
  assign uif.bus_wr    = wr_reg;
  assign uif.bus_size  = size_reg;
  assign uif.bus_addr  = addr_reg;
  assign uif.bus_wdata = wdata_reg;

  assign uif.i_done  = (state_reg == RESP) && (grant_reg == GRANT_I) && !kill_flag_reg;
  assign uif.d_done  = (state_reg == RESP) && (grant_reg == GRANT_D);
  assign uif.i_rdata = rdata_reg;
  assign uif.d_rdata = rdata_reg;

  assign uif.busy = (state_reg != IDLE);

  // -------------------------------------------------------------------------
  // Protocol sanity
  // -------------------------------------------------------------------------
  a_done_onehot : assert property (@(posedge clk) disable iff (!resetn)
    !(uif.i_done && uif.d_done));

  a_req_implies_busy : assert property (@(posedge clk) disable iff (!resetn)
    !uif.bus_req || uif.busy);

endmodule

// File: tb/tb_uncache_arbiter.sv
module tb_uncache_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  uncache_arbiter_if uif();

  uncache_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .uif    (uif)
  );

  typedef struct {
    string       name;
    // inputs
    logic        ir;
    logic [31:0] i_addr;
    logic        kl;
    logic        dr;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    // expected outputs
    logic        e_breq;
    logic        e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_chk_wd;
    logic        e_idone;
    logic        e_ddone;
    logic [31:0] e_rdata;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // current requester fields and expected bus fields, used while building
  logic [31:0] cur_i_addr;
  logic        cur_d_wr;
  logic [1:0]  cur_d_size;
  logic [31:0] cur_d_addr, cur_d_wdata;
  logic        ex_wr, ex_chk_wd;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata;

  function automatic void set_d(logic wr, logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
    cur_d_wr = wr; cur_d_size = sz; cur_d_addr = a; cur_d_wdata = wd;
  endfunction

  function automatic void exp_bus(logic wr, logic [1:0] sz, logic [31:0] a, logic [31:0] wd, logic cw);
    ex_wr = wr; ex_size = sz; ex_addr = a; ex_wdata = wd; ex_chk_wd = cw;
  endfunction

  function automatic void add(string nm, logic ir, logic dr, logic kl, logic aok, logic dok,
                              logic [31:0] rd, logic ebr, logic eid, logic edd, logic eb,
                              logic [31:0] erd);
    vec_t v;
    v.name = nm; v.ir = ir; v.i_addr = cur_i_addr; v.kl = kl; v.dr = dr;
    v.d_wr = cur_d_wr; v.d_size = cur_d_size; v.d_addr = cur_d_addr; v.d_wdata = cur_d_wdata;
    v.aok = aok; v.dok = dok; v.rd = rd;
    v.e_breq = ebr; v.e_wr = ex_wr; v.e_size = ex_size; v.e_addr = ex_addr;
    v.e_wdata = ex_wdata; v.e_chk_wd = ex_chk_wd;
    v.e_idone = eid; v.e_ddone = edd; v.e_rdata = erd; v.e_busy = eb;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    uif.i_req = 1'b0; uif.i_addr = 32'd0; uif.i_kill = 1'b0;
    uif.d_req = 1'b0; uif.d_wr = 1'b0; uif.d_size = 2'd0;
    uif.d_addr = 32'd0; uif.d_wdata = 32'd0;
    uif.bus_addr_ok = 1'b0; uif.bus_data_ok = 1'b0; uif.bus_rdata = 32'd0;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, ".bus_req"},   32'(uif.bus_req),   32'd0);
    chk({tag, ".bus_wr"},    32'(uif.bus_wr),    32'd0);
    chk({tag, ".bus_size"},  32'(uif.bus_size),  32'd0);
    chk({tag, ".bus_addr"},  uif.bus_addr,       32'd0);
    chk({tag, ".bus_wdata"}, uif.bus_wdata,      32'd0);
    chk({tag, ".i_done"},    32'(uif.i_done),    32'd0);
    chk({tag, ".d_done"},    32'(uif.d_done),    32'd0);
    chk({tag, ".i_rdata"},   uif.i_rdata,        32'd0);
    chk({tag, ".d_rdata"},   uif.d_rdata,        32'd0);
    chk({tag, ".busy"},      32'(uif.busy),      32'd0);
    $display("check %s: outputs all zero", tag);
  endtask

  task automatic apply_range(int lo, int hi);
    for (int k = lo; k < hi; k++) begin
      vec_t v;
      v = tbl[k];
      @(negedge clk);
      uif.i_req = v.ir; uif.i_addr = v.i_addr; uif.i_kill = v.kl;
      uif.d_req = v.dr; uif.d_wr = v.d_wr; uif.d_size = v.d_size;
      uif.d_addr = v.d_addr; uif.d_wdata = v.d_wdata;
      uif.bus_addr_ok = v.aok; uif.bus_data_ok = v.dok; uif.bus_rdata = v.rd;
      #1;
      chk({v.name, ".bus_req"}, 32'(uif.bus_req), 32'(v.e_breq));
      if (v.e_breq) begin
        chk({v.name, ".bus_wr"},   32'(uif.bus_wr),   32'(v.e_wr));
        chk({v.name, ".bus_size"}, 32'(uif.bus_size), 32'(v.e_size));
        chk({v.name, ".bus_addr"}, uif.bus_addr,      v.e_addr);
        if (v.e_chk_wd) chk({v.name, ".bus_wdata"}, uif.bus_wdata, v.e_wdata);
      end
      chk({v.name, ".i_done"}, 32'(uif.i_done), 32'(v.e_idone));
      chk({v.name, ".d_done"}, 32'(uif.d_done), 32'(v.e_ddone));
      chk({v.name, ".busy"},   32'(uif.busy),   32'(v.e_busy));
      if (v.e_idone) chk({v.name, ".i_rdata"}, uif.i_rdata, v.e_rdata);
      if (v.e_ddone) chk({v.name, ".d_rdata"}, uif.d_rdata, v.e_rdata);
      $display("vec %-8s ir=%0b dr=%0b kill=%0b aok=%0b dok=%0b | breq=%0b addr=%h idone=%0b ddone=%0b rdata=%h busy=%0b",
               v.name, v.ir, v.dr, v.kl, v.aok, v.dok, uif.bus_req, uif.bus_addr,
               uif.i_done, uif.d_done, uif.d_rdata, uif.busy);
    end
  endtask

  int a_end;

  initial begin
    drive_idle();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");

    // ---------------- part A: load, store, kill ----------------
    cur_i_addr = 32'h1FC0_0000;
    // Data word load: request at T, addr_ok T+2, data_ok T+4, done T+5
    set_d(1'b0, 2'd2, 32'h1FAF_F000, 32'd0);
    exp_bus(1'b0, 2'd2, 32'h1FAF_F000, 32'd0, 1'b1);
    //   name      ir dr kl aok dok rd             breq id dd busy rdata
    add("ld_t0",   0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0);
    add("ld_t1",   0, 1, 0, 0, 1, 32'h9999_9999,  1, 0, 0, 1, 32'h0); // stray data_ok
    add("ld_t2",   0, 1, 0, 1, 0, 32'h0,          1, 0, 0, 1, 32'h0);
    add("ld_t3",   0, 1, 0, 1, 0, 32'h0,          0, 0, 0, 1, 32'h0); // addr_ok in DATA ignored
    add("ld_t4",   0, 1, 0, 0, 1, 32'hDEAD_BEEF,  0, 0, 0, 1, 32'h0);
    add("ld_t5",   0, 0, 0, 0, 0, 32'h0,          0, 0, 1, 1, 32'hDEAD_BEEF);
    add("ld_t6",   0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0);

    // Byte store; requester fields changed mid-transaction have no effect
    set_d(1'b1, 2'd0, 32'h1FAF_F004, 32'h0000_00A5);
    exp_bus(1'b1, 2'd0, 32'h1FAF_F004, 32'h0000_00A5, 1'b1);
    add("st_t0",   0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0);
    add("st_t1",   0, 1, 0, 0, 0, 32'h0,          1, 0, 0, 1, 32'h0);
    set_d(1'b0, 2'd2, 32'h1234_5678, 32'hFFFF_FFFF);
    add("st_t2",   0, 1, 0, 1, 0, 32'h0,          1, 0, 0, 1, 32'h0);
    add("st_t3",   0, 1, 0, 0, 1, 32'h0,          0, 0, 0, 1, 32'h0);
    add("st_t4",   0, 0, 0, 0, 0, 32'h0,          0, 0, 1, 1, 32'h0);
    add("st_t5",   0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0);

    // Kill during DATA; the pending data request is granted next
    set_d(1'b0, 2'd2, 32'h1FAF_F008, 32'd0);
    exp_bus(1'b0, 2'd2, 32'h1FC0_0000, 32'd0, 1'b0);
    add("k0",      1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0);
    add("k1",      1, 1, 0, 1, 0, 32'h0,          1, 0, 0, 1, 32'h0);
    add("k2",      1, 1, 1, 0, 0, 32'h0,          0, 0, 0, 1, 32'h0);
    add("k3",      0, 1, 0, 0, 1, 32'hCAFE_F00D,  0, 0, 0, 1, 32'h0);
    add("k4",      0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 1, 32'h0);
    exp_bus(1'b0, 2'd2, 32'h1FAF_F008, 32'd0, 1'b1);
    add("k5",      0, 1, 1, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0); // kill in IDLE
    add("k6",      0, 1, 1, 1, 1, 32'h0BAD_CAFE,  1, 0, 0, 1, 32'h0); // kill while grant=D
    add("k7",      0, 0, 0, 0, 0, 32'h0,          0, 0, 1, 1, 32'h0BAD_CAFE);
    add("k8",      0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0);
    a_end = tbl.size();

    @(negedge clk) resetn = 1'b1;
    apply_range(0, a_end);

    // ---------------- reset in the middle of DATA ----------------
    @(negedge clk);
    uif.d_req = 1'b1; uif.d_wr = 1'b0; uif.d_size = 2'd2;
    uif.d_addr = 32'h1FAF_F00C; uif.d_wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    uif.bus_addr_ok = 1'b1;
    @(negedge clk);
    uif.bus_addr_ok = 1'b0;
    #1;
    chk("rst_pre.busy",    32'(uif.busy),    32'd1);
    chk("rst_pre.bus_req", 32'(uif.bus_req), 32'd0);
    #2 resetn = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    resetn = 1'b1;
    uif.d_req = 1'b0;
    uif.bus_data_ok = 1'b1;
    uif.bus_rdata = 32'hAAAA_AAAA;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rst_post.i_done", 32'(uif.i_done), 32'd0);
      chk("rst_post.d_done", 32'(uif.d_done), 32'd0);
      chk("rst_post.busy",   32'(uif.busy),   32'd0);
      $display("check rst_post cycle %0d: idone=%0b ddone=%0b busy=%0b",
               c, uif.i_done, uif.d_done, uif.busy);
      @(negedge clk);
      uif.bus_data_ok = 1'b0;
    end

    // ---------------- part B: tie round-robin from reset ----------------
    cur_i_addr = 32'h1FC0_0000;
    set_d(1'b0, 2'd2, 32'h1FAF_F000, 32'd0);
    exp_bus(1'b0, 2'd2, 32'h1FAF_F000, 32'd0, 1'b1);
    add("rr_c0",   1, 1, 0, 1, 1, 32'h0,          0, 0, 0, 0, 32'h0);
    add("rr_c1",   1, 1, 0, 1, 1, 32'hD000_0001,  1, 0, 0, 1, 32'h0);
    add("rr_c2",   1, 1, 0, 1, 1, 32'h5555_5555,  0, 0, 1, 1, 32'hD000_0001);
    add("rr_c3",   1, 1, 0, 1, 1, 32'h7777_7777,  0, 0, 0, 0, 32'h0);
    exp_bus(1'b0, 2'd2, 32'h1FC0_0000, 32'd0, 1'b0);
    add("rr_c4",   1, 1, 0, 1, 1, 32'h1111_1111,  1, 0, 0, 1, 32'h0);
    add("rr_c5",   1, 1, 0, 1, 1, 32'h0,          0, 1, 0, 1, 32'h1111_1111);
    add("rr_c6",   1, 1, 0, 1, 1, 32'h0,          0, 0, 0, 0, 32'h0);
    exp_bus(1'b0, 2'd2, 32'h1FAF_F000, 32'd0, 1'b1);
    add("rr_c7",   1, 1, 0, 1, 1, 32'hD000_0002,  1, 0, 0, 1, 32'h0);
    add("rr_c8",   1, 1, 0, 1, 1, 32'h0,          0, 0, 1, 1, 32'hD000_0002);
    add("rr_c9",   1, 1, 0, 1, 1, 32'h0,          0, 0, 0, 0, 32'h0);
    exp_bus(1'b0, 2'd2, 32'h1FC0_0000, 32'd0, 1'b0);
    add("rr_c10",  1, 1, 0, 1, 1, 32'h1111_1112,  1, 0, 0, 1, 32'h0);
    add("rr_c11",  0, 0, 0, 1, 1, 32'h0,          0, 1, 0, 1, 32'h1111_1112);
    add("rr_c12",  0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0);
    apply_range(a_end, tbl.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
